// File: rtl/diff_fifo_drain_pkg.sv
// Shared constants for the difference-FIFO drain: word/beat geometry,
// FSM encodings and the syn_reg1 status-word layout.
package diff_fifo_drain_pkg;

    localparam int BEAT_W = 32;
    localparam int WORD_W = 128;
    localparam int BEATS  = 4;
    localparam int IDX_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // syn_reg1 = {28'b0, busy, 1'b0, state, stall, beat, word}
    localparam int SYN_W         = 128;
    localparam int SYN_WORD_LSB  = 0;
    localparam int SYN_BEAT_LSB  = 32;
    localparam int SYN_STALL_LSB = 64;
    localparam int SYN_STATE_LSB = 96;
    localparam int SYN_BUSY_LSB  = 99;

    function automatic logic [BEAT_W-1:0] beat_of(input logic [WORD_W-1:0] word,
                                                  input logic [IDX_W-1:0]  idx);
        return word[int'(idx)*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/diff_fifo_drain_if.sv
// FIFO read side plus downstream beat stream of the drain.
interface diff_fifo_drain_if;
    import diff_fifo_drain_pkg::*;

    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic [BEAT_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );

endinterface

// File: rtl/diff_fifo_drain_stat_counter.sv
// Statistics counter with synchronous clear (priority over increment)
// and optional saturation at all-ones; wraps otherwise.
module drain_stat_counter #(
    parameter int unsigned W        = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(SATURATE && (count_q == '1))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/diff_fifo_drain.sv
// Drains 128-bit words from the difference FIFO and streams them as four
// 32-bit beats (LSB first) with statistics and a registered status word.
module diff_fifo_drain
    import diff_fifo_drain_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    diff_fifo_drain_if.master drain,
    input  logic              turn2run,
    output logic [SYN_W-1:0]  syn_reg1,
    output logic [1:0]        debug_state
);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] hold_q,  hold_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              valid_q, valid_d;
    logic [SYN_W-1:0]  syn_q,   syn_d;

    logic              xfer;
    logic              last_beat;
    logic              rd_go;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    assign xfer      = valid_q && drain.m_ready;
    assign last_beat = (idx_q == IDX_W'(BEATS - 1));
    assign rd_go     = (state_q == ST_IDLE) && !drain.fifo_empty;

    // Read strobe is combinational so the word arrives while in CAP; the
    // reset term keeps it low while the flops are held.
    assign drain.fifo_rd_en = rd_go && !s_axi_areset;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_go) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                hold_d  = drain.fifo_rd_data;
                idx_d   = '0;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_beat) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign drain.m_data  = beat_of(hold_q, idx_q);
    assign drain.m_valid = valid_q;
    assign drain.m_last  = valid_q && last_beat;

    drain_stat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_word_cnt (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .clr   (turn2run),
        .inc   (xfer && last_beat),
        .count (word_cnt)
    );

    drain_stat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_beat_cnt (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .clr   (turn2run),
        .inc   (xfer),
        .count (beat_cnt)
    );

    drain_stat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_stall_cnt (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .clr   (turn2run),
        .inc   (valid_q && !drain.m_ready),
        .count (stall_cnt)
    );

    always_comb begin
        syn_d = '0;
        syn_d[SYN_WORD_LSB  +: CNT_W] = word_cnt;
        syn_d[SYN_BEAT_LSB  +: CNT_W] = beat_cnt;
        syn_d[SYN_STALL_LSB +: CNT_W] = stall_cnt;
        syn_d[SYN_STATE_LSB +: 2]     = state_q;
        syn_d[SYN_BUSY_LSB]           = (state_q != ST_IDLE);
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            syn_q <= '0;
        end else begin
            syn_q <= syn_d;
        end
    end

    assign syn_reg1    = syn_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_diff_fifo_drain.sv
// Directed bench for diff_fifo_drain: default-width instance plus a
// CNT_W=4 instance for wrap/saturation, each fed by a queue-backed FIFO model.
module tb_diff_fifo_drain;

    logic         clk;
    logic         rst;
    logic         t2r;
    logic         t2r4;
    logic [127:0] syn;
    logic [127:0] syn4;
    logic [1:0]   dbg;
    logic [1:0]   dbg4;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] q[$];
    logic [127:0] q4[$];
    event         pre_edge;

    diff_fifo_drain_if bus ();
    diff_fifo_drain_if bus4 ();

    diff_fifo_drain dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .drain        (bus),
        .turn2run     (t2r),
        .syn_reg1     (syn),
        .debug_state  (dbg)
    );

    diff_fifo_drain #(.CNT_W(4)) dut4 (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .drain        (bus4),
        .turn2run     (t2r4),
        .syn_reg1     (syn4),
        .debug_state  (dbg4)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #4 -> pre_edge;
            #1 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [127:0] w);
        q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic push4(input logic [127:0] w);
        q4.push_back(w);
        bus4.fifo_empty = 1'b0;
    endtask

    // Advance one clock; called at/just after a negedge, returns at the next
    // negedge. Read data appears shortly after the edge that saw fifo_rd_en.
    task automatic tick();
        logic p;
        logic p4;
        @(pre_edge);
        p  = bus.fifo_rd_en;
        p4 = bus4.fifo_rd_en;
        @(posedge clk);
        #1;
        if (p) begin
            if (q.size() > 0) bus.fifo_rd_data = q.pop_front();
            bus.fifo_empty = (q.size() == 0);
        end
        if (p4) begin
            if (q4.size() > 0) bus4.fifo_rd_data = q4.pop_front();
            bus4.fifo_empty = (q4.size() == 0);
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.m_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, bus.m_valid, 1'b1);
    endtask

    task automatic expect_word(input string tag, input logic [127:0] w);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", tag, i), bus.m_data, w[32*i +: 32]);
            check($sformatf("%s_l%0d", tag, i), bus.m_last, (i == 3));
            check($sformatf("%s_v%0d", tag, i), bus.m_valid, 1'b1);
            tick();
        end
    endtask

    localparam logic [127:0] W1 = 128'h00000003_00000002_00000001_00000000;
    localparam logic [127:0] W2 = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    localparam logic [127:0] W3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] W4 = 128'h0DDC0FFE_0BADBEEF_CAFEF00D_12345678;
    localparam logic [127:0] W5 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] W6 = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001;
    localparam logic [127:0] W7 = 128'hF00DF00D_E00DE00D_D00DD00D_C00DC00D;

    initial begin
        int n;
        rst = 1'b1;
        t2r = 1'b0;
        t2r4 = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = '0;
        bus.m_ready = 1'b1;
        bus4.fifo_empty = 1'b1;
        bus4.fifo_rd_data = '0;
        bus4.m_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state, with a word already waiting in the FIFO
        check("rst_valid", bus.m_valid, 1'b0);
        check("rst_last", bus.m_last, 1'b0);
        check("rst_data", bus.m_data, 32'h0);
        check("rst_state", dbg, 2'd0);
        check("rst_syn", syn, 128'h0);
        check("rst_syn4", syn4, 128'h0);
        push(W1);
        #1;
        check("rst_rd_en", bus.fifo_rd_en, 1'b0);

        // Basic word, m_ready=1, latency 2
        rst = 1'b0;
        #1;
        check("rd_en_first", bus.fifo_rd_en, 1'b1);
        n = 0;
        while (!bus.m_valid && n < 10) begin
            tick();
            n++;
        end
        check("latency", n, 2);
        expect_word("w1", W1);
        check("w1_done_valid", bus.m_valid, 1'b0);
        check("w1_done_state", dbg, 2'd0);
        tick();
        check("w1_syn", syn, {32'd0, 32'd0, 32'd4, 32'd1});

        // Stall 5 cycles on beat 2, with the next word already queued
        push(W2);
        wait_valid("w2_valid");
        check("w2_d0", bus.m_data, W2[31:0]);
        tick();
        check("w2_d1", bus.m_data, W2[63:32]);
        tick();
        push(W3);
        bus.m_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_data%0d", i), bus.m_data, W2[95:64]);
            check($sformatf("stall_rden%0d", i), bus.fifo_rd_en, 1'b0);
            check($sformatf("stall_last%0d", i), bus.m_last, 1'b0);
            tick();
        end
        bus.m_ready = 1'b1;
        #1;
        check("w2_d2", bus.m_data, W2[95:64]);
        tick();
        check("w2_d3", bus.m_data, W2[127:96]);
        check("w2_l3", bus.m_last, 1'b1);
        tick();
        check("w2_done_valid", bus.m_valid, 1'b0);
        check("w3_rd_en", bus.fifo_rd_en, 1'b1);
        tick();
        check("w2_syn", syn[95:0], {32'd5, 32'd8, 32'd2});
        wait_valid("w3_valid");
        expect_word("w3", W3);
        tick();
        check("w3_syn", syn[95:0], {32'd5, 32'd12, 32'd3});

        // FIFO empty for 20 cycles
        for (int i = 0; i < 20; i++) begin
            check($sformatf("idle_rden%0d", i), bus.fifo_rd_en, 1'b0);
            check($sformatf("idle_state%0d", i), dbg, 2'd0);
            tick();
        end
        check("idle_syn", syn, {32'd0, 32'd5, 32'd12, 32'd3});

        // turn2run mid-word (no abort) and on the final-beat transfer
        push(W4);
        wait_valid("w4_valid");
        check("w4_d0", bus.m_data, W4[31:0]);
        tick();
        check("w4_d1", bus.m_data, W4[63:32]);
        t2r = 1'b1;
        tick();
        t2r = 1'b0;
        check("w4_d2", bus.m_data, W4[95:64]);
        check("w4_v2", bus.m_valid, 1'b1);
        tick();
        check("w4_d3", bus.m_data, W4[127:96]);
        check("w4_l3", bus.m_last, 1'b1);
        t2r = 1'b1;
        tick();
        t2r = 1'b0;
        check("t2r_valid", bus.m_valid, 1'b0);
        check("t2r_state", dbg, 2'd0);
        tick();
        check("t2r_syn", syn, 128'h0);

        // Reset during beat 1 discards the word
        push(W5);
        wait_valid("w5_valid");
        check("w5_d0", bus.m_data, W5[31:0]);
        tick();
        check("w5_d1", bus.m_data, W5[63:32]);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.m_valid, 1'b0);
        check("mid_rst_last", bus.m_last, 1'b0);
        check("mid_rst_data", bus.m_data, 32'h0);
        check("mid_rst_state", dbg, 2'd0);
        @(negedge clk);
        tick();
        check("mid_rst_syn", syn, 128'h0);
        check("mid_rst_rden", bus.fifo_rd_en, 1'b0);
        rst = 1'b0;
        push(W6);
        wait_valid("w6_valid");
        expect_word("w6", W6);

        // CNT_W=4: 17 words wrap word_count, stall_count saturates at 15
        for (int i = 0; i < 17; i++) begin
            push4({32'(i), 32'(i + 100), 32'(i + 200), 32'(i + 300)});
        end
        n = 0;
        while (!(q4.size() == 0 && dbg4 == 2'd0 && !bus4.m_valid) && n < 300) begin
            tick();
            n++;
        end
        check("c4_drain_done", (n < 300), 1'b1);
        tick();
        check("c4_wrap_syn", syn4, {32'd0, 32'd0, 32'd4, 32'd1});
        push4(W7);
        n = 0;
        while (!bus4.m_valid && n < 20) begin
            tick();
            n++;
        end
        check("c4_valid", bus4.m_valid, 1'b1);
        bus4.m_ready = 1'b0;
        repeat (20) tick();
        check("c4_hold_data", bus4.m_data, W7[31:0]);
        check("c4_stall_sat", syn4[95:64], 32'd15);
        bus4.m_ready = 1'b1;
        n = 0;
        while (bus4.m_valid && n < 10) begin
            tick();
            n++;
        end
        check("c4_beats", n, 4);
        tick();
        check("c4_final_syn", syn4[95:0], {32'd15, 32'd8, 32'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
